ps2_key_event_queue: RTL and testbench

Parametrised successor of the single-key PS/2 display controller: consumes scan-code bytes from the `ps2_keyboard` byte interface, decodes make/break/extended (E0) sequences with a 4-state prefix FSM, and queues decoded key events in a DEPTH-entry FIFO with a valid/ready output. It also tracks the currently held key, counts presses, and optionally filters typematic repeats. It sits between `ps2_keyboard` and consumers such as `scan_code2ascii`, `counter`, and the seven-segment display logic.

---
 rtl/ps2_key_event_queue.sv | 153 +++++++++++++++
 tb/tb_ps2_key_event_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code decoder (make/break/E0) with held-key tracking, press counter and a show-ahead event FIFO.
// Optional typematic-repeat filtering is compiled in with `define KEYQ_REPEAT_FILTER_EN.
module ps2_key_event_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     ps2_ready,
  input  logic [7:0]               ps2_data,
  output logic                     ps2_nextdata_n,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [7:0]               evt_code,
  output logic                     evt_ext,
  output logic                     evt_break,
  output logic                     held,
  output logic [7:0]               cur_code,
  output logic                     cur_ext,
  output logic [CNT_W-1:0]         press_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     ovf_clr
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state, next_state;

  logic          rdy_d;
  logic          accept;
  logic          is_e0, is_f0, discard;
  logic          ev, ev_ext, ev_brk, match, repeat_hit;
  logic          push_reg;
  logic [9:0]    push_word;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr, drop;
  logic [9:0]    head;

  assign accept  = ps2_ready & ~rdy_d;
  assign is_e0   = (ps2_data == 8'hE0);
  assign is_f0   = (ps2_data == 8'hF0);
  assign discard = (ps2_data == 8'hAA) || (ps2_data == 8'hFA) ||
                   (ps2_data == 8'hEE) || (ps2_data == 8'h00);

  always_comb begin
    next_state = state;
    ev         = 1'b0;
    ev_ext     = 1'b0;
    ev_brk     = 1'b0;
    case (state)
      IDLE: begin
        if (is_e0)         next_state = EXT;
        else if (is_f0)    next_state = BRK;
        else if (!discard) ev = 1'b1;
      end
      EXT: begin
        if (is_f0)      next_state = EXT_BRK;
        else if (!is_e0) begin
          ev         = 1'b1;
          ev_ext     = 1'b1;
          next_state = IDLE;
        end
      end
      BRK: begin
        next_state = IDLE;
        ev_brk     = 1'b1;
        ev         = ~(is_e0 | is_f0);
      end
      default: begin
        next_state = IDLE;
        ev_brk     = 1'b1;
        ev_ext     = 1'b1;
        ev         = ~(is_e0 | is_f0);
      end
    endcase
  end

  assign match = held && (cur_code == ps2_data) && (cur_ext == ev_ext);
`ifdef KEYQ_REPEAT_FILTER_EN
  assign repeat_hit = ev && !ev_brk && match;
`else
  assign repeat_hit = 1'b0;
`endif

  // Decode and key tracking happen on the detection edge; the FIFO write lags one cycle via push_reg.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state          <= IDLE;
      rdy_d          <= 1'b0;
      ps2_nextdata_n <= 1'b1;
      push_reg       <= 1'b0;
      push_word      <= '0;
      held           <= 1'b0;
      cur_code       <= 8'h00;
      cur_ext        <= 1'b0;
      press_count    <= '0;
    end else begin
      rdy_d          <= ps2_ready;
      ps2_nextdata_n <= ~accept;
      push_reg       <= 1'b0;
      if (accept) begin
        state <= next_state;
        if (ev && !repeat_hit) begin
          push_reg  <= 1'b1;
          push_word <= {ev_brk, ev_ext, ps2_data};
          if (!ev_brk) begin
            held        <= 1'b1;
            cur_code    <= ps2_data;
            cur_ext     <= ev_ext;
            press_count <= press_count + CNT_W'(1);
          end else if (match) begin
            held     <= 1'b0;
            cur_code <= 8'h00;
            cur_ext  <= 1'b0;
          end
        end
      end
    end
  end

  assign full = (fifo_level == (AW+1)'(DEPTH));
  assign pop  = evt_valid & evt_ready;
  assign wr   = push_reg & (~full | pop);
  assign drop = push_reg & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !pop)      fifo_level <= fifo_level + (AW+1)'(1);
      else if (pop && !wr) fifo_level <= fifo_level - (AW+1)'(1);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign evt_valid = (fifo_level != '0);
  assign head      = mem[rd_ptr];
  assign evt_code  = evt_valid ? head[7:0] : 8'h00;
  assign evt_ext   = evt_valid & head[8];
  assign evt_break = evt_valid & head[9];
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Scoreboard bench for ps2_key_event_queue: directed byte sequences, a monitor pops expected events.
module tb_ps2_key_event_queue;
  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_ready = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_nextdata_n;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       held;
  logic [7:0] cur_code;
  logic       cur_ext;
  logic [7:0] press_count;
  logic [3:0] fifo_level;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  ps2_key_event_queue #(.DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
    .ps2_nextdata_n(ps2_nextdata_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break), .held(held),
    .cur_code(cur_code), .cur_ext(cur_ext), .press_count(press_count),
    .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] code; logic ext; logic brk;} evt_t;
  evt_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   nd_low = 0;
  int   nd_falls = 0;
  logic nd_prev = 1'b1;
  logic [7:0] codes [0:8] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
    evt_t e;
    e.code = code; e.ext = ext; e.brk = brk;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    evt_t e;
    forever begin
      @(negedge clk);
      if (!ps2_nextdata_n) begin
        nd_low++;
        if (nd_prev) nd_falls++;
      end
      nd_prev = ps2_nextdata_n;
      if (clrn && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=%h/%b/%b expected=none", evt_code, evt_ext, evt_break);
        end else begin
          e = exp_q.pop_front();
          $display("event code=%h ext=%b break=%b (expected %h/%b/%b)",
                   evt_code, evt_ext, evt_break, e.code, e.ext, e.brk);
          chk("event", {22'd0, evt_code, evt_ext, evt_break}, {22'd0, e.code, e.ext, e.brk});
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ps2_data  = b;
    ps2_ready = 1'b1;
    repeat (3) @(negedge clk);
    ps2_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    for (int i = 0; i < 40 && fifo_level != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_level", 32'(fifo_level), 0);
    chk("drain_queue", exp_q.size(), 0);
    chk("empty_head", {22'd0, evt_code, evt_ext, evt_break}, 0);
    evt_ready = 1'b0;
  endtask

  initial begin
    int nd0, f0;
    fork monitor(); join_none
    do_reset();
    chk("rst_nextdata", 32'(ps2_nextdata_n), 1);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_press", 32'(press_count), 0);

    // Basic make / break.
    nd0 = nd_low; f0 = nd_falls;
    evt_ready = 1'b1;
    expect_evt(8'h1C, 1'b0, 1'b0);
    send(8'h1C);
    chk("t1_held", 32'(held), 1);
    chk("t1_cur_code", 32'(cur_code), 32'h1C);
    send(8'hF0);
    expect_evt(8'h1C, 1'b0, 1'b1);
    send(8'h1C);
    chk("t1_press", 32'(press_count), 1);
    chk("t1_released", 32'(held), 0);
    chk("t1_nd_low_cycles", nd_low - nd0, 3);
    chk("t1_nd_pulses", nd_falls - f0, 3);
    drain();

    // Extended key.
    expect_evt(8'h75, 1'b1, 1'b0);
    send(8'hE0); send(8'h75);
    chk("t2_cur_ext", 32'(cur_ext), 1);
    chk("t2_cur_code", 32'(cur_code), 32'h75);
    expect_evt(8'h75, 1'b1, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t2_cur_code_rel", 32'(cur_code), 0);
    chk("t2_held_rel", 32'(held), 0);
    chk("t2_press", 32'(press_count), 2);
    drain();

    // Typematic repeats.
    do_reset();
    evt_ready = 1'b1;
    expect_evt(8'h1C, 1'b0, 1'b0);
`ifndef KEYQ_REPEAT_FILTER_EN
    expect_evt(8'h1C, 1'b0, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b0);
`endif
    send(8'h1C); send(8'h1C); send(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b1);
    send(8'hF0); send(8'h1C);
`ifdef KEYQ_REPEAT_FILTER_EN
    chk("t3_press", 32'(press_count), 1);
`else
    chk("t3_press", 32'(press_count), 3);
`endif
    drain();

    // Overflow: 9 makes into an 8-deep FIFO with no consumer.
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_evt(codes[i], 1'b0, 1'b0);
      send(codes[i]);
    end
    chk("t4_level", 32'(fifo_level), 8);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_head", 32'(evt_code), 32'h15);
    chk("t4_press", 32'(press_count), 9);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 0);

    // Full FIFO: push and pop land on the same edge.
    expect_evt(8'h4B, 1'b0, 1'b0);
    fork
      send(8'h4B);
      begin
        @(negedge clk);
        @(posedge clk); #1 evt_ready = 1'b1;
        @(posedge clk); #1 evt_ready = 1'b0;
      end
    join
    chk("t5_level", 32'(fifo_level), 8);
    chk("t5_overflow", 32'(overflow), 0);
    chk("t5_press", 32'(press_count), 10);
    drain();

    // Reset in the middle of an E0,F0 sequence.
    do_reset();
    evt_ready = 1'b1;
    expect_evt(8'h1C, 1'b0, 1'b0);
    send(8'h1C);
    send(8'hE0); send(8'hF0);
    chk("t6_pre_held", 32'(held), 1);
    @(negedge clk); clrn = 1'b0;
    @(negedge clk);
    chk("t6_rst_held", 32'(held), 0);
    chk("t6_rst_code", 32'(cur_code), 0);
    chk("t6_rst_ext", 32'(cur_ext), 0);
    chk("t6_rst_press", 32'(press_count), 0);
    chk("t6_rst_level", 32'(fifo_level), 0);
    chk("t6_rst_valid", 32'(evt_valid), 0);
    chk("t6_rst_ovf", 32'(overflow), 0);
    chk("t6_rst_nd", 32'(ps2_nextdata_n), 1);
    clrn = 1'b1;
    expect_evt(8'h75, 1'b0, 1'b0);
    send(8'h75);
    chk("t6_held_after", 32'(held), 1);
    chk("t6_ext_after", 32'(cur_ext), 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
